temperature_accept_controller: RTL and testbench

TEMPERATURE_ACCEPT_CONTROLLER -- requirements
Module: temperature_accept_controller

---
 rtl/temperature_accept_controller.sv | 140 ++++++++++++++
 tb/tb_temperature_accept_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/temperature_accept_controller.sv
// Temperature sample accept/reject controller: screens each sample against the running history
// average, with a one-deep pending buffer. Optional macro TEMP_ANOMALY_COUNTER_EN enables anomalyCount.
module temperature_accept_controller #(
   parameter int TEMPERATURE_WIDTH     = 16,
   parameter int TEMPERATURES_TO_TRACK = 16,
   parameter int ANOMALY_MARGIN        = 8,
   parameter int SETTLE_CYCLES         = 2,
   parameter int REJECT_LIMIT          = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         temperatureReceived,
   input  logic [TEMPERATURE_WIDTH-1:0] receivedTemperature,
   input  logic [TEMPERATURE_WIDTH-1:0] averageTemperature,
   output logic                         acceptTemperature,
   output logic                         temperatureReady,
   output logic [TEMPERATURE_WIDTH-1:0] temperature,
   output logic                         anomaly,
   output logic                         historyFull,
   output logic                         overrun,
   output logic [7:0]                   anomalyCount
);
   localparam int W      = TEMPERATURE_WIDTH;
   localparam int FILL_W = $clog2(TEMPERATURES_TO_TRACK + 1);
   localparam int REJ_W  = $clog2(REJECT_LIMIT + 1);
   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, CHECK, ACCEPT, SETTLE, REJECT} state_t;

   state_t              stateReg, stateNext;
   logic [W-1:0]        sampleReg, pendingReg, temperatureReg;
   logic                pendingValidReg, overrunReg, readyReg, readyNext;
   logic [FILL_W-1:0]   fillCountReg;
   logic [REJ_W-1:0]    rejectCountReg;
   logic [SET_W-1:0]    settleCountReg;
   logic signed [W:0]   diff;
   logic [W:0]          absDiff;
   logic                withinMargin, startCheck, rejectLimitHit;

   // Widened by one bit so the unsigned difference and its magnitude never truncate
   always_comb begin
      diff    = $signed({1'b0, sampleReg}) - $signed({1'b0, averageTemperature});
      absDiff = diff[W] ? -diff : diff;
   end

   assign withinMargin   = absDiff <= (W+1)'(ANOMALY_MARGIN);
   assign rejectLimitHit = rejectCountReg == REJ_W'(REJECT_LIMIT);
   assign startCheck     = (stateReg == IDLE) && (pendingValidReg || temperatureReceived);
   assign historyFull    = fillCountReg == FILL_W'(TEMPERATURES_TO_TRACK);
   assign temperature    = temperatureReg;
   assign temperatureReady = readyReg;
   assign overrun        = overrunReg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stateReg <= IDLE;
      else       stateReg <= stateNext;
   end

   always_comb begin
      stateNext         = stateReg;
      acceptTemperature = 1'b0;
      anomaly           = 1'b0;
      readyNext         = 1'b0;
      case (stateReg)
         IDLE:   if (startCheck) stateNext = CHECK;
         CHECK:  stateNext = (!historyFull || withinMargin || rejectLimitHit) ? ACCEPT : REJECT;
         ACCEPT: begin
            acceptTemperature = 1'b1;
            stateNext         = SETTLE;
         end
         SETTLE: if (settleCountReg == SET_W'(SETTLE_CYCLES - 1)) begin
            stateNext = IDLE;
            readyNext = 1'b1;
         end
         REJECT: begin
            anomaly   = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Sample capture: pending sample has priority in IDLE; a new pulse then refills the buffer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sampleReg       <= '0;
         pendingReg      <= '0;
         pendingValidReg <= 1'b0;
         overrunReg      <= 1'b0;
      end else if (stateReg == IDLE && pendingValidReg) begin
         sampleReg       <= pendingReg;
         pendingValidReg <= temperatureReceived;
         if (temperatureReceived) pendingReg <= receivedTemperature;
      end else if (stateReg == IDLE && temperatureReceived) begin
         sampleReg <= receivedTemperature;
      end else if (temperatureReceived) begin
         if (pendingValidReg) begin
            overrunReg <= 1'b1;
         end else begin
            pendingReg      <= receivedTemperature;
            pendingValidReg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         temperatureReg <= '0;
         fillCountReg   <= '0;
         rejectCountReg <= '0;
         settleCountReg <= '0;
         readyReg       <= 1'b0;
      end else begin
         readyReg <= readyNext;
         case (stateReg)
            ACCEPT: begin
               temperatureReg <= sampleReg;
               rejectCountReg <= '0;
               settleCountReg <= '0;
               if (!historyFull) fillCountReg <= fillCountReg + 1'b1;
            end
            SETTLE: settleCountReg <= settleCountReg + 1'b1;
            REJECT: if (!rejectLimitHit) rejectCountReg <= rejectCountReg + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef TEMP_ANOMALY_COUNTER_EN
   logic [7:0] anomalyCountReg;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          anomalyCountReg <= '0;
      else if (stateReg == REJECT && anomalyCountReg != 8'hFF) anomalyCountReg <= anomalyCountReg + 8'd1;
   end
   assign anomalyCount = anomalyCountReg;
`else
   assign anomalyCount = 8'd0;
`endif

endmodule

// File: tb/tb_temperature_accept_controller.sv
// Directed self-checking bench for temperature_accept_controller (default parameters).
module tb_temperature_accept_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        recv = 1'b0;
   logic [15:0] rxT = '0;
   logic [15:0] avg = 16'd100;
   logic        acc, ready, anom, full, ovr;
   logic [15:0] temp;
   logic [7:0]  aCnt;

   int total = 0;
   int bad = 0;
   int rejTotal = 0;

   temperature_accept_controller dut (
      .clk(clk), .reset(rst), .temperatureReceived(recv), .receivedTemperature(rxT),
      .averageTemperature(avg), .acceptTemperature(acc), .temperatureReady(ready),
      .temperature(temp), .anomaly(anom), .historyFull(full), .overrun(ovr),
      .anomalyCount(aCnt)
   );

   always #5 clk = ~clk;

   function automatic int expCount(input int rejects);
`ifdef TEMP_ANOMALY_COUNTER_EN
      return (rejects > 255) ? 255 : rejects;
`else
      return 0;
`endif
   endfunction

   // Pulse one sample and observe 10 cycles; lat counts cycles from the pulse cycle to temperatureReady
   task automatic doSample(input logic [15:0] v, output int nAcc, output int nAnom, output int lat);
      recv = 1'b1; rxT = v; nAcc = 0; nAnom = 0; lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 0) recv = 1'b0;
         if (acc) nAcc++;
         if (anom) nAnom++;
         if (ready && lat < 0) lat = i + 1;
      end
      $display("sample=%0d avg=%0d accepts=%0d anomalies=%0d latency=%0d temp=%0d full=%0b cnt=%0d",
               v, avg, nAcc, nAnom, lat, temp, full, aCnt);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk); #1;
      total++; if ({acc, ready, anom, full, ovr} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {acc, ready, anom, full, ovr}); end
      total++; if (temp !== 16'd0) begin bad++; $display("FAIL reset_temp got=%0d want=0", temp); end
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if ({acc, ready, anom, full, ovr} !== 5'b0) begin bad++; $display("FAIL idle_flags got=%b want=00000", {acc, ready, anom, full, ovr}); end
      total++; if (aCnt !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", aCnt); end
   endtask

   task automatic test_fill();
      int a, n, l;
      avg = 16'd100;
      for (int k = 0; k < 16; k++) begin
         total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_early[%0d] got=%0b want=0", k, full); end
         doSample(16'd100, a, n, l);
         total++; if (a !== 1 || n !== 0) begin bad++; $display("FAIL fill_acc[%0d] got acc=%0d anom=%0d want 1/0", k, a, n); end
         total++; if (l !== 5) begin bad++; $display("FAIL fill_latency[%0d] got=%0d want=5", k, l); end
         repeat (10) @(posedge clk); #1;
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b want=1", full); end
      total++; if (temp !== 16'd100) begin bad++; $display("FAIL fill_temp got=%0d want=100", temp); end
   endtask

   task automatic test_margin();
      logic [15:0] vals [5] = '{16'd108, 16'd109, 16'd92, 16'd91, 16'd100};
      int          expAcc [5] = '{1, 0, 1, 0, 1};
      logic [15:0] expTemp [5] = '{16'd108, 16'd108, 16'd92, 16'd92, 16'd100};
      int a, n, l;
      for (int k = 0; k < 5; k++) begin
         doSample(vals[k], a, n, l);
         if (expAcc[k] == 0) rejTotal++;
         total++; if (a !== expAcc[k] || n !== 1 - expAcc[k]) begin bad++; $display("FAIL margin_acc[%0d] got acc=%0d anom=%0d want acc=%0d", k, a, n, expAcc[k]); end
         total++; if (temp !== expTemp[k]) begin bad++; $display("FAIL margin_temp[%0d] got=%0d want=%0d", k, temp, expTemp[k]); end
         total++; if (aCnt !== 8'(expCount(rejTotal))) begin bad++; $display("FAIL margin_count[%0d] got=%0d want=%0d", k, aCnt, expCount(rejTotal)); end
      end
   endtask

   task automatic test_force();
      int a, n, l;
      for (int k = 0; k < 5; k++) begin
         doSample(16'd200, a, n, l);
         if (k < 4) begin
            rejTotal++;
            total++; if (a !== 0 || n !== 1) begin bad++; $display("FAIL force_reject[%0d] got acc=%0d anom=%0d want 0/1", k, a, n); end
         end else begin
            total++; if (a !== 1 || n !== 0) begin bad++; $display("FAIL force_accept got acc=%0d anom=%0d want 1/0", a, n); end
         end
      end
      total++; if (temp !== 16'd200) begin bad++; $display("FAIL force_temp got=%0d want=200", temp); end
      total++; if (aCnt !== 8'(expCount(rejTotal))) begin bad++; $display("FAIL force_count got=%0d want=%0d", aCnt, expCount(rejTotal)); end
   endtask

   task automatic test_back_to_back();
      int nAcc = 0, nRdy = 0;
      int rdyLat [2] = '{-1, -1};
      total++; if (ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr_before got=%0b want=0", ovr); end
      recv = 1'b1; rxT = 16'd100;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (i == 0) rxT = 16'd101;
         if (i == 1) rxT = 16'd102;
         if (i == 2) recv = 1'b0;
         if (acc) nAcc++;
         if (ready) begin
            if (nRdy < 2) rdyLat[nRdy] = i + 1;
            nRdy++;
         end
      end
      $display("back_to_back accepts=%0d readies=%0d lat0=%0d lat1=%0d temp=%0d overrun=%0b", nAcc, nRdy, rdyLat[0], rdyLat[1], temp, ovr);
      total++; if (nAcc !== 2 || nRdy !== 2) begin bad++; $display("FAIL b2b_counts got acc=%0d rdy=%0d want 2/2", nAcc, nRdy); end
      total++; if (rdyLat[0] !== 5 || rdyLat[1] !== 10) begin bad++; $display("FAIL b2b_latency got=%0d,%0d want=5,10", rdyLat[0], rdyLat[1]); end
      total++; if (temp !== 16'd101) begin bad++; $display("FAIL b2b_temp got=%0d want=101", temp); end
      total++; if (ovr !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%0b want=1", ovr); end
   endtask

   task automatic test_reset_mid();
      int spur = 0;
      int a, n, l;
      recv = 1'b1; rxT = 16'd100;
      @(posedge clk); #1; recv = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      total++; if ({acc, ready, anom, full, ovr} !== 5'b0) begin bad++; $display("FAIL midrst_flags got=%b want=00000", {acc, ready, anom, full, ovr}); end
      total++; if (temp !== 16'd0 || aCnt !== 8'd0) begin bad++; $display("FAIL midrst_regs got temp=%0d cnt=%0d want 0/0", temp, aCnt); end
      @(posedge clk); #1; rst = 1'b0;
      rejTotal = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (acc || ready || anom) spur++;
      end
      $display("reset_mid spurious=%0d", spur);
      total++; if (spur !== 0) begin bad++; $display("FAIL midrst_spurious got=%0d want=0", spur); end
      doSample(16'd77, a, n, l);
      total++; if (a !== 1 || n !== 0 || l !== 5) begin bad++; $display("FAIL midrst_next got acc=%0d anom=%0d lat=%0d want 1/0/5", a, n, l); end
      total++; if (temp !== 16'd77) begin bad++; $display("FAIL midrst_temp got=%0d want=77", temp); end
   endtask

   task automatic test_anomaly_count();
      int a, n, l;
      int anomSeen = 0;
      for (int k = 0; k < 16; k++) doSample(16'd100, a, n, l);
      total++; if (full !== 1'b1) begin bad++; $display("FAIL count_full got=%0b want=1", full); end
      // Every fifth sample is a forced accept, so 375 samples yield 300 rejects
      for (int k = 0; k < 375; k++) begin
         doSample(16'd200, a, n, l);
         anomSeen += n;
      end
      rejTotal += 300;
      total++; if (anomSeen !== 300) begin bad++; $display("FAIL count_pulses got=%0d want=300", anomSeen); end
      total++; if (aCnt !== 8'(expCount(rejTotal))) begin bad++; $display("FAIL count_sat got=%0d want=%0d", aCnt, expCount(rejTotal)); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_margin();
      test_force();
      test_back_to_back();
      test_reset_mid();
      test_anomaly_count();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
